ahb_lite_mailbox: RTL and testbench
===================================

Name: ahb_lite_mailbox

Overview:
- Responder (peripheral) on the team's simplified AHB-Lite bus: trans/write/waddr/wdata in, readyout/rdata out.
- Exposes a byte FIFO mailbox plus status and error registers to an initiator (Controller-class master).
- Inserts a configurable number of wait states per transfer, so initiators are exercised against a stalling responder.
- Raises irq while data is pending.

Parameters:
- DEPTH, 8, FIFO entries; legal range 2..15.
- WAIT_STATES, 1, cycles readyout is held low per data phase; legal range 0..7.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- trans  in  1  transfer request; valid address phase when trans=1 and readyout=1 at a rising edge
- write  in  1  1=write, 0=read; sampled with trans
- waddr  in  8  register address; sampled with trans
- wdata  in  8  write data; sampled at the data-phase completion edge
- readyout  out  1  0 = stall the current data phase
- rdata  out  8  read data; valid only while readyout=1 in a read data phase, else 8'h00
- irq  out  1  registered; 1 when FIFO is non-empty

Behaviour:
- Reset (asynchronous, rst_n=0):
  - readyout=1, rdata=0, irq=0, FIFO empty, sticky flags=0, ERRCNT=0, state IDLE.
  - An in-flight transfer is aborted; its write is lost and its pop does not occur.
- Register map:
  - 0x00 DATA: write pushes, read pops.
  - 0x01 STATUS: [7] full, [6] empty, [5] overflow sticky, [4] underflow sticky, [3:0] count. Writing 1 to bit 5 or bit 4 clears it (W1C); other bits are read-only.
  - 0x02 ERRCNT: read-only, saturates at 8'hFF.
  - All other addresses: reads return 0, writes are ignored.
- State machine, IDLE / WAIT / DATA:
  - IDLE: readyout=1. A rising edge with trans=1 latches write and waddr. Next state is WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else DATA.
  - WAIT: readyout=0. Counter decrements; at 0 the next state is DATA.
  - DATA: readyout=1. The rising edge at the end of this cycle is the completion edge, where the write or pop takes effect.
  - If trans=1 at the completion edge, the new transfer is accepted (back-to-back pipelining) and the state goes to WAIT or DATA as from IDLE; otherwise it goes to IDLE.
- Latency: data phase lasts 1+WAIT_STATES cycles after the address phase.
- rdata is combinational from the latched address and current registered state, so a read immediately following a write observes that write.
- Write DATA when full: data dropped; overflow=1; ERRCNT+1.
- Read DATA when empty: rdata=0x00; underflow=1; ERRCNT+1.
- Pointers wrap modulo DEPTH. Count width is 4 bits; full when count==DEPTH.
- One bus transfer per cycle at most, so a push and a pop never coincide.
- If W1C and a new error event land on the same completion edge, the set wins. (This case is unreachable with a single port and is documented for formal checking only.)
- irq updates on the edge after the count changes.
- trans changing during WAIT is ignored; only IDLE and DATA cycles sample it.

Decomposition:
- Package ahb_mailbox_pkg holds:
  - address constants ADDR_DATA, ADDR_STATUS, ADDR_ERRCNT;
  - STATUS bit positions;
  - state encoding IDLE/WAIT/DATA.
- One sub-module, ahb_fifo_core: synchronous FIFO with push/pop/full/empty/count, parameter DEPTH, async active-low reset.
- The bus FSM, register decode and error logic stay in ahb_lite_mailbox.

Test Plan:
- Reset then idle, WAIT_STATES=1: readyout=1, rdata=0, irq=0; read STATUS -> 8'h40.
- Write 0x11, 0x22, 0x33 to 0x00 back-to-back: readyout low exactly 1 cycle per transfer; STATUS -> 8'h03; irq=1 one edge after first push.
- Read 0x00 three times: rdata 0x11, 0x22, 0x33 in order; STATUS -> 8'h40; irq drops to 0.
- Read 0x00 when empty: rdata=0x00; STATUS -> 8'h50; ERRCNT -> 1. Write 8'h10 to STATUS: STATUS -> 8'h40.
- Push 9 bytes with DEPTH=8: 9th dropped; STATUS -> 8'hA8; ERRCNT incremented; WAIT_STATES=0 build shows readyout constantly 1.
- Assert rst_n=0 during WAIT of a write to 0x00: readyout=1 immediately; FIFO empty after release; a subsequent read returns underflow behaviour.

Source files
------------

// File: rtl/ahb_mailbox_pkg.sv
// Shared definitions for the AHB-Lite mailbox: register addresses, STATUS
// bit positions and the bus state encoding.
package ahb_mailbox_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_ERRCNT = 8'h02;

  localparam int STAT_FULL  = 7;
  localparam int STAT_EMPTY = 6;
  localparam int STAT_OVF   = 5;
  localparam int STAT_UNF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } bus_state_e;

endpackage

// File: rtl/ahb_fifo_core.sv
// Byte-wide synchronous FIFO with occupancy count; pointers wrap modulo DEPTH
// so non-power-of-two depths work.
module ahb_fifo_core #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        count  <= count + 4'd1;
      end else if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        count  <= count - 4'd1;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_mailbox.sv
// AHB-Lite responder exposing a byte FIFO mailbox, STATUS and ERRCNT registers,
// with a fixed number of wait states per data phase and a data-pending irq.
module ahb_lite_mailbox
  import ahb_mailbox_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       trans,
  input  logic       write,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  output logic       readyout,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  bus_state_e state;
  logic [2:0] wait_cnt;
  logic       wr_q;
  logic [7:0] addr_q;
  logic       ovf;
  logic       unf;
  logic [7:0] errcnt;

  logic       done, is_data, is_stat;
  logic       push, pop, ovf_evt, unf_evt, w1c;
  logic       full, empty;
  logic [3:0] count;
  logic [7:0] head;
  logic [7:0] status_val;

  ahb_fifo_core #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The last cycle of DATA is the completion edge: all side effects happen here.
  assign done    = (state == DATA);
  assign is_data = (addr_q == ADDR_DATA);
  assign is_stat = (addr_q == ADDR_STATUS);
  assign push    = done && wr_q && is_data && !full;
  assign pop     = done && !wr_q && is_data && !empty;
  assign ovf_evt = done && wr_q && is_data && full;
  assign unf_evt = done && !wr_q && is_data && empty;
  assign w1c     = done && wr_q && is_stat;

  always_comb begin
    status_val             = {4'd0, count};
    status_val[STAT_FULL]  = full;
    status_val[STAT_EMPTY] = empty;
    status_val[STAT_OVF]   = ovf;
    status_val[STAT_UNF]   = unf;
  end

  always_comb begin
    rdata = 8'h00;
    if (done && !wr_q) begin
      case (addr_q)
        ADDR_DATA:   rdata = empty ? 8'h00 : head;
        ADDR_STATUS: rdata = status_val;
        ADDR_ERRCNT: rdata = errcnt;
        default:     rdata = 8'h00;
      endcase
    end
  end

  // Bus FSM; IDLE and DATA both act as address phases, giving back-to-back pipelining.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      readyout <= 1'b1;
    end else begin
      case (state)
        IDLE, DATA: begin
          if (trans) begin
            wr_q   <= write;
            addr_q <= waddr;
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= WS_LOAD;
              readyout <= 1'b0;
            end else begin
              state    <= DATA;
              readyout <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            readyout <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state    <= DATA;
            readyout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          state    <= IDLE;
          readyout <= 1'b1;
        end
      endcase
    end
  end

  // Sticky flags: a new error event outranks a same-edge W1C.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ovf    <= 1'b0;
      unf    <= 1'b0;
      errcnt <= 8'h00;
      irq    <= 1'b0;
    end else begin
      if (ovf_evt)                      ovf <= 1'b1;
      else if (w1c && wdata[STAT_OVF]) ovf <= 1'b0;
      if (unf_evt)                      unf <= 1'b1;
      else if (w1c && wdata[STAT_UNF]) unf <= 1'b0;
      if ((ovf_evt || unf_evt) && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      irq <= !empty;
    end
  end

endmodule

// File: tb/tb_ahb_lite_mailbox.sv
// Directed bench for ahb_lite_mailbox: one WAIT_STATES=1 instance for the main
// scenarios plus a WAIT_STATES=0 instance for the zero-wait build.
module tb_ahb_lite_mailbox;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       trans = 1'b0;
  logic       write = 1'b0;
  logic [7:0] waddr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       readyout;
  logic [7:0] rdata;
  logic       irq;

  logic       trans0 = 1'b0;
  logic       write0 = 1'b0;
  logic [7:0] waddr0 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic       readyout0;
  logic [7:0] rdata0;
  logic       irq0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ahb_lite_mailbox #(.DEPTH(8), .WAIT_STATES(1)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .trans    (trans),
    .write    (write),
    .waddr    (waddr),
    .wdata    (wdata),
    .readyout (readyout),
    .rdata    (rdata),
    .irq      (irq)
  );

  ahb_lite_mailbox #(.DEPTH(8), .WAIT_STATES(0)) dut0 (
    .clock    (clock),
    .rst_n    (rst_n),
    .trans    (trans0),
    .write    (write0),
    .waddr    (waddr0),
    .wdata    (wdata0),
    .readyout (readyout0),
    .rdata    (rdata0),
    .irq      (irq0)
  );

  // Address phase: present the request, let the next rising edge accept it.
  task automatic start_xfer(input logic wr, input logic [7:0] addr);
    trans = 1'b1;
    write = wr;
    waddr = addr;
    @(posedge clock);
    #1;
    trans = 1'b0;
  endtask

  // Wait for readyout at negedges; returns in the DATA cycle before completion.
  task automatic data_wait(output logic [7:0] rd, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (readyout === 1'b1) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    rd = rdata;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL data_wait_timeout: readyout=%b after %0d cycles, need 1", readyout, stalls);
    end
  endtask

  task automatic single(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int stalls);
    wdata = wd;
    start_xfer(wr, addr);
    data_wait(rd, stalls);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int st;
    n_cmp++; if (readyout !== 1'b1) begin n_bad++; $display("FAIL reset_readyout: got %b need 1", readyout); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h need 00", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b need 0", irq); end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h40) begin n_bad++; $display("FAIL reset_status: got %h need 40", rd); end
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL reset_stalls: got %0d need 1", st); end
    single(1'b0, 8'h02, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL reset_errcnt: got %h need 00", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int st;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    trans = 1'b1; write = 1'b1; waddr = 8'h00; wdata = vals[0];
    @(posedge clock);
    #1;
    trans = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_cmp++; if (readyout !== 1'b0) begin n_bad++; $display("FAIL b2b_wait%0d: readyout %b need 0", k, readyout); end
      if (k == 1) begin
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL b2b_irq_early: got %b need 0", irq); end
      end
      @(negedge clock);
      n_cmp++; if (readyout !== 1'b1) begin n_bad++; $display("FAIL b2b_data%0d: readyout %b need 1", k, readyout); end
      if (k == 1) begin
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq_set: got %b need 1", irq); end
      end
      if (k < 2) begin
        trans = 1'b1; write = 1'b1; waddr = 8'h00;
      end
      @(posedge clock);
      #1;
      trans = 1'b0;
      if (k < 2) wdata = vals[k+1];
    end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL b2b_status: got %h need 03", rd); end
  endtask

  task automatic test_drain();
    logic [7:0] rd;
    int st;
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      single(1'b0, 8'h00, 8'h00, rd, st);
      n_cmp++; if (rd !== exp_v[k]) begin n_bad++; $display("FAIL drain_data%0d: got %h need %h", k, rd, exp_v[k]); end
    end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h40) begin n_bad++; $display("FAIL drain_status: got %h need 40", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL drain_irq: got %b need 0", irq); end
  endtask

  task automatic test_underflow();
    logic [7:0] rd;
    int st;
    single(1'b0, 8'h00, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unf_rdata: got %h need 00", rd); end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h50) begin n_bad++; $display("FAIL unf_status: got %h need 50", rd); end
    single(1'b0, 8'h02, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL unf_errcnt: got %h need 01", rd); end
    single(1'b1, 8'h01, 8'h10, rd, st);
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h40) begin n_bad++; $display("FAIL unf_w1c: got %h need 40", rd); end
  endtask

  task automatic test_overflow();
    logic [7:0] rd;
    int st;
    for (int k = 0; k < 9; k++) begin
      single(1'b1, 8'h00, 8'hA0 + 8'(k), rd, st);
      n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL ovf_write_rdata%0d: got %h need 00", k, rd); end
    end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'hA8) begin n_bad++; $display("FAIL ovf_status: got %h need A8", rd); end
    single(1'b1, 8'h02, 8'h00, rd, st);
    single(1'b0, 8'h02, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL ovf_errcnt: got %h need 02", rd); end
    single(1'b0, 8'h07, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unmapped_read: got %h need 00", rd); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ovf_irq: got %b need 1", irq); end
    single(1'b0, 8'h00, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'hA0) begin n_bad++; $display("FAIL ovf_head: got %h need A0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int st;
    wdata = 8'h77;
    start_xfer(1'b1, 8'h00);
    n_cmp++; if (readyout !== 1'b0) begin n_bad++; $display("FAIL rstmid_inwait: readyout %b need 0", readyout); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (readyout !== 1'b1) begin n_bad++; $display("FAIL rstmid_readyout: got %b need 1", readyout); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rstmid_irq: got %b need 0", irq); end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h40) begin n_bad++; $display("FAIL rstmid_status: got %h need 40", rd); end
    single(1'b0, 8'h00, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rstmid_read: got %h need 00", rd); end
    single(1'b0, 8'h01, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h50) begin n_bad++; $display("FAIL rstmid_unf: got %h need 50", rd); end
    single(1'b0, 8'h02, 8'h00, rd, st);
    n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL rstmid_errcnt: got %h need 01", rd); end
  endtask

  task automatic test_wait0();
    trans0 = 1'b1; write0 = 1'b1; waddr0 = 8'h00; wdata0 = 8'h5A;
    @(posedge clock);
    #1;
    write0 = 1'b0;
    @(negedge clock);
    n_cmp++; if (readyout0 !== 1'b1) begin n_bad++; $display("FAIL ws0_wr_ready: got %b need 1", readyout0); end
    @(posedge clock);
    #1;
    trans0 = 1'b0;
    @(negedge clock);
    n_cmp++; if (readyout0 !== 1'b1) begin n_bad++; $display("FAIL ws0_rd_ready: got %b need 1", readyout0); end
    n_cmp++; if (rdata0 !== 8'h5A) begin n_bad++; $display("FAIL ws0_rdata: got %h need 5A", rdata0); end
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL ws0_irq_early: got %b need 0", irq0); end
    @(negedge clock);
    n_cmp++; if (irq0 !== 1'b1) begin n_bad++; $display("FAIL ws0_irq_set: got %b need 1", irq0); end
    n_cmp++; if (readyout0 !== 1'b1) begin n_bad++; $display("FAIL ws0_idle_ready: got %b need 1", readyout0); end
    @(negedge clock);
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL ws0_irq_clr: got %b need 0", irq0); end
    n_cmp++; if (rdata0 !== 8'h00) begin n_bad++; $display("FAIL ws0_idle_rdata: got %h need 00", rdata0); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_back_to_back();
    test_drain();
    test_underflow();
    test_overflow();
    test_wait0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need test completion");
    $fatal(1, "watchdog");
  end

endmodule
